// File: rtl/spu_rf_pkg.sv
// rtl/spu_rf_pkg.sv - shared types, default sizes and lane packing helper for the SPU register file
package spu_rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int SPU_QUADWORD  = 128;
    localparam int SPU_REG_COUNT = 128;

    // Base bit offset of lane `lane` in a packed bus of `width`-bit lanes.
    function automatic int lane_slice(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/spu_rf_wr_arb.sv
// rtl/spu_rf_wr_arb.sv - per-lane winning-write mask and same-cycle address collision detect
module spu_rf_wr_arb
    import spu_rf_pkg::*;
#(
    parameter int NUM_WR = 2,
    parameter int ADDR_W = 7
) (
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    output logic [NUM_WR-1:0]        o_wr_eff,
    output logic                     o_collide
);

    logic [ADDR_W-1:0] w_addr [NUM_WR];

    for (genvar g = 0; g < NUM_WR; g++) begin : g_unpack
        assign w_addr[g] = i_wr_addr[lane_slice(g, ADDR_W) +: ADDR_W];
    end

    // A lane loses whenever any higher-numbered enabled lane targets the same entry.
    always_comb begin
        o_wr_eff  = i_wr_en;
        o_collide = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            for (int j = k + 1; j < NUM_WR; j++) begin
                if (i_wr_en[k] && i_wr_en[j] && (w_addr[k] == w_addr[j])) begin
                    o_wr_eff[k] = 1'b0;
                    o_collide   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spu_regfile_mp.sv
// rtl/spu_regfile_mp.sv - multi-port SPU register file with clear sweep; SPU_RF_BYPASS_EN enables write-to-read bypass
module spu_regfile_mp
    import spu_rf_pkg::*;
#(
    parameter int DATA_W = SPU_QUADWORD,
    parameter int DEPTH  = SPU_REG_COUNT,
    parameter int NUM_WR = 2,
    parameter int NUM_RD = 6,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic                     o_rf_ready,
    output logic                     o_wr_collide,
    output logic [ADDR_W-1:0]        o_clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_t         r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_rf_ready;
    logic              r_wr_collide;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] w_wr_addr [NUM_WR];
    logic [DATA_W-1:0] w_wr_data [NUM_WR];
    logic [NUM_WR-1:0] w_wr_eff;
    logic              w_collide;

    for (genvar g = 0; g < NUM_WR; g++) begin : g_wr_unpack
        assign w_wr_addr[g] = i_wr_addr[lane_slice(g, ADDR_W) +: ADDR_W];
        assign w_wr_data[g] = i_wr_data[lane_slice(g, DATA_W) +: DATA_W];
    end

    spu_rf_wr_arb #(
        .NUM_WR (NUM_WR),
        .ADDR_W (ADDR_W)
    ) u_wr_arb (
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .o_wr_eff  (w_wr_eff),
        .o_collide (w_collide)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= CLEAR;
            r_clr_idx    <= '0;
            r_rf_ready   <= 1'b0;
            r_wr_collide <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_idx    <= r_clr_idx + 1'b1;
                    r_wr_collide <= 1'b0;
                    if (r_clr_idx == LAST_IDX) begin
                        r_state    <= RUN;
                        r_rf_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_wr_collide <= w_collide;
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    // Storage has no reset; the sweep zeroes it. Winners are unique per address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_idx] <= '0;
            end else begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (w_wr_eff[k]) begin
                        r_mem[w_wr_addr[k]] <= w_wr_data[k];
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] w_rd_addr;
        logic [DATA_W-1:0] w_rd_data;

        assign w_rd_addr = i_rd_addr[lane_slice(j, ADDR_W) +: ADDR_W];

        always_comb begin
            w_rd_data = r_mem[w_rd_addr];
`ifdef SPU_RF_BYPASS_EN
            if (r_state == RUN) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (w_wr_eff[k] && (w_wr_addr[k] == w_rd_addr)) begin
                        w_rd_data = w_wr_data[k];
                    end
                end
            end
`endif
        end

        assign o_rd_data[lane_slice(j, DATA_W) +: DATA_W] = w_rd_data;
    end

    assign o_rf_ready   = r_rf_ready;
    assign o_wr_collide = r_wr_collide;
    assign o_clr_idx    = r_clr_idx;

endmodule

// File: tb/tb_spu_regfile_mp.sv
// tb/tb_spu_regfile_mp.sv - directed self-checking bench for spu_regfile_mp at default sizes
module tb_spu_regfile_mp;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 128;
    localparam int NUM_WR = 2;
    localparam int NUM_RD = 6;
    localparam int ADDR_W = 7;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     rf_ready;
    logic                     wr_collide;
    logic [ADDR_W-1:0]        clr_idx;

    int tests = 0;
    int fails = 0;
    int n;

    localparam logic [DATA_W-1:0] PAT_A = {32{4'hA}};
    localparam logic [DATA_W-1:0] PAT_5 = {32{4'h5}};

    always #5 clk = ~clk;

    spu_regfile_mp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR),
        .NUM_RD (NUM_RD),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_rf_ready   (rf_ready),
        .o_wr_collide (wr_collide),
        .o_clr_idx    (clr_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input int lane, input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en[lane]                    = en;
        wr_addr[lane*ADDR_W +: ADDR_W] = a;
        wr_data[lane*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_rd(input int port, input logic [ADDR_W-1:0] a);
        rd_addr[port*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [DATA_W-1:0] rd(input int port);
        return rd_data[port*DATA_W +: DATA_W];
    endfunction

    initial begin
        reset   = 1'b1;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        step();
        reset = 1'b0;
        check("reset_ready", 128'(rf_ready), 128'(0));
        check("reset_clr_idx", 128'(clr_idx), 128'(0));
        check("reset_collide", 128'(wr_collide), 128'(0));

        n = 0;
        while (!rf_ready && n < 300) begin
            step();
            n++;
        end
        check("sweep_cycles", 128'(n), 128'(128));
        check("run_clr_idx", 128'(clr_idx), 128'(0));
        set_rd(0, 7'd0);
        set_rd(1, 7'd64);
        set_rd(2, 7'd127);
        #1;
        check("clr_rd0", rd(0), '0);
        check("clr_rd64", rd(1), '0);
        check("clr_rd127", rd(2), '0);

        // Restart mid-sweep; writes during the sweep must be dropped.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) step();
        check("mid_clr_idx", 128'(clr_idx), 128'(50));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("restart_clr_idx", 128'(clr_idx), 128'(0));
        check("restart_ready", 128'(rf_ready), 128'(0));
        set_wr(0, 1'b1, 7'd120, 128'hFF);
        set_wr(1, 1'b1, 7'd120, 128'hFF);
        n = 0;
        while (!rf_ready && n < 300) begin
            step();
            n++;
        end
        wr_en = '0;
        check("restart_cycles", 128'(n), 128'(128));
        check("clear_collide", 128'(wr_collide), 128'(0));
        set_rd(0, 7'd120);
        #1;
        check("clear_wr_ignored", rd(0), '0);

        set_wr(0, 1'b1, 7'd5, PAT_A);
        set_wr(1, 1'b1, 7'd9, PAT_5);
        step();
        wr_en = '0;
        set_rd(0, 7'd5);
        set_rd(1, 7'd9);
        #1;
        check("dual_wr_lane0", rd(0), PAT_A);
        check("dual_wr_lane1", rd(1), PAT_5);
        check("dual_wr_collide", 128'(wr_collide), 128'(0));

        set_wr(0, 1'b1, 7'd3, 128'h1);
        set_wr(1, 1'b1, 7'd3, 128'h2);
        step();
        wr_en = '0;
        set_rd(0, 7'd3);
        #1;
        check("collide_winner", rd(0), 128'h2);
        check("collide_flag", 128'(wr_collide), 128'(1));
        step();
        check("collide_clears", 128'(wr_collide), 128'(0));

        set_wr(0, 1'b1, 7'd4, 128'h11);
        set_wr(1, 1'b0, 7'd4, 128'h22);
        step();
        wr_en = '0;
        set_rd(0, 7'd4);
        #1;
        check("disabled_lane_data", rd(0), 128'h11);
        check("disabled_lane_collide", 128'(wr_collide), 128'(0));

        set_wr(0, 1'b0, 7'd0, '0);
        set_wr(1, 1'b1, 7'd7, 128'hDEAD);
        set_rd(2, 7'd7);
        #1;
`ifdef SPU_RF_BYPASS_EN
        check("raw_same_cycle", rd(2), 128'hDEAD);
`else
        check("raw_same_cycle", rd(2), '0);
`endif
        step();
        wr_en = '0;
        #1;
        check("raw_next_cycle", rd(2), 128'hDEAD);

        set_wr(0, 1'b1, 7'd127, 128'hC0);
        set_wr(1, 1'b1, 7'd127, 128'hC1);
        set_rd(5, 7'd127);
        #1;
`ifdef SPU_RF_BYPASS_EN
        check("bypass_priority", rd(5), 128'hC1);
`else
        check("bypass_priority", rd(5), '0);
`endif
        step();
        wr_en = '0;
        #1;
        check("edge_addr127", rd(5), 128'hC1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spu_regfile_mp.md
Name: spu_regfile_mp

Overview:
- Parametrised multi-port register file for the dual-issue SPU pipeline; successor to the fixed 2-write/6-read quadword file.
- Generalised in issue-lane count (write ports), read-port count, data width and depth.
- Adds a sequential clear sweep with a ready handshake, same-cycle write-to-read bypass, deterministic write-collision priority, and a registered collision flag.
- Sits between the decode/operand-fetch stage and the even/odd execution pipes.

Parameters:
- DATA_W, 128, register width in bits (quadword).
- DEPTH, 128, number of registers; power of two, >= 2.
- NUM_WR, 2, write ports (one per issue lane).
- NUM_RD, 6, read ports.
- ADDR_W, $clog2(DEPTH), register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- wr_en  in  NUM_WR  per-lane write enable.
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses; lane k at bits [k*ADDR_W +: ADDR_W].
- wr_data  in  NUM_WR*DATA_W  packed write data; same lane packing as wr_addr.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses.
- rd_data  out  NUM_RD*DATA_W  packed read data; combinational.
- rf_ready  out  1  high when the clear sweep is done and the file accepts writes.
- wr_collide  out  1  registered flag: previous cycle had two or more enabled lanes with equal addresses.
- clr_idx  out  ADDR_W  current sweep index (debug).

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- FSM states: CLEAR, RUN.
- Reset:
  - Forces state CLEAR, clr_idx=0, rf_ready=0, wr_collide=0.
  - Reset asserted mid-sweep restarts the sweep at index 0.
- CLEAR:
  - Each cycle writes 0 to entry clr_idx and increments clr_idx.
  - When clr_idx==DEPTH-1 is written: go to RUN, clr_idx wraps to 0, and rf_ready=1 from the next cycle.
  - A full clear takes DEPTH cycles after reset deasserts.
  - All wr_en are ignored in CLEAR.
  - Reads in CLEAR return stored contents: cleared entries read 0, uncleared entries are undefined; callers must wait for rf_ready.
- RUN:
  - For each lane k with wr_en[k]=1, the entry at wr_addr[k] takes wr_data[k] at the clk edge.
  - Write latency: 1 cycle to storage.
  - Collision rule: the highest-numbered enabled lane wins (the odd pipe wins over the even pipe when NUM_WR=2).
  - wr_collide = 1 in the cycle after any collision, otherwise 0. Disabled lanes never count toward a collision.
- Reads:
  - rd_data[j] = entry[rd_addr[j]], with bypass (see Optional Feature).
  - Any number of read ports may share an address.
  - Address width is exact; there are no out-of-range addresses.
- rf_ready stays 1 until the next reset.

Optional Feature:
- Macro: SPU_RF_BYPASS_EN.
- Defined:
  - In RUN, a read whose address matches an enabled write lane in the same cycle returns that lane's wr_data combinationally.
  - Multiple matches resolve with the same highest-lane priority.
  - Read-after-write is visible in 0 cycles.
- Undefined: reads return storage only, so newly written data is visible the cycle after the write edge.
- Bypass is inactive in CLEAR.

Decomposition:
- Package spu_rf_pkg holds:
  - typedef rf_state_t enum {CLEAR, RUN};
  - the default constants SPU_QUADWORD=128 and SPU_REG_COUNT=128;
  - a function lane_slice for packed-port extraction.
- One sub-module, spu_rf_wr_arb: takes wr_en/wr_addr across lanes and produces a per-lane "effective write" mask (winning lanes only) plus the combinational collide signal. The bypass mux reuses the mask.

Test Plan:
- Pulse reset for 1 cycle, then hold idle: rf_ready=0 for exactly 128 cycles, rises on cycle 129; reads of addresses 0, 64 and 127 return 0.
- Assert reset again at sweep cycle 50 for 1 cycle: clr_idx returns to 0 and rf_ready rises 128 cycles after the deassert.
- In RUN, lane0 writes addr 5 = 0xAAAA...A and lane1 writes addr 9 = 0x5555...5 in the same cycle; next cycle rd_addr0=5 and rd_addr1=9 return those values; wr_collide=0.
- Both lanes write addr 3 in the same cycle (lane0=0x1, lane1=0x2): next cycle addr 3 reads 0x2 and wr_collide=1; a following idle cycle gives wr_collide=0.
- With SPU_RF_BYPASS_EN, lane1 writes addr 7=0xDEAD while rd_addr2=7 in the same cycle: rd_data2=0xDEAD immediately. Without the macro: old value in that cycle, 0xDEAD the next cycle.
- Assert wr_en during CLEAR to addr 120=0xFF: no effect; after rf_ready, addr 120 reads 0.
